// File: rtl/axis_fifo_pkg.sv
// Shared helpers for stream queues: pointer width and power-of-two test.
package axis_fifo_pkg;

  // Pointer width for a queue of the given depth: index bits plus one wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream link carrying tvalid/tready/tdata between a manager and a subordinate.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset so
// it can map onto distributed RAM.
module axis_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one beat per accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with first-word fall-through output, a
// synchronous flush and an occupancy count. Ready towards the producer is
// derived from registers only, so no combinational path crosses the queue.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_if.s                     axis_sif,
  axis_if.m                     axis_mif,
  input  logic                  flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int TDATA_WIDTH = axis_sif.TDATA_WIDTH;
  localparam int AW          = $clog2(DEPTH);
  localparam int PTR_W       = fifo_ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $fatal(1, "axis_fifo: DEPTH must be a power of two and at least 2");
  end

  if (axis_mif.TDATA_WIDTH != axis_sif.TDATA_WIDTH) begin : g_bad_width
    $fatal(1, "axis_fifo: manager and subordinate TDATA_WIDTH differ");
  end

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   init_done_q, init_done_d;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   mem_we;
  logic [TDATA_WIDTH-1:0] rd_data;

  // Full: same index, opposite wrap bit. Empty: identical pointers.
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign axis_sif.tready = init_done_q && !full;
  assign axis_mif.tvalid = !empty;
  assign axis_mif.tdata  = rd_data;

  assign push   = axis_sif.tvalid && axis_sif.tready;
  assign pop    = axis_mif.tvalid && axis_mif.tready;
  assign mem_we = push && !flush;
  assign count  = wr_ptr_q - rd_ptr_q;

  // Next-state pointers: flush empties the queue and wins over push/pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    init_done_d = 1'b1;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State registers; reset drops all stored beats at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (TDATA_WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (axis_sif.tdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_axis_fifo.sv
// Testbench for axis_fifo: inputs change 1 ns after the rising edge, the
// monitor samples on the falling edge. Expected beats come from a queue fed
// by the stimulus side; the monitor pops and compares on every output handshake.
module tb_axis_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;

  axis_if #(.TDATA_WIDTH(W)) s_if ();
  axis_if #(.TDATA_WIDTH(W)) m_if ();

  axis_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axis_sif (s_if),
    .axis_mif (m_if),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_rx     = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state owned by the monitor: occupancy and ready-after-reset.
  int           cnt_m    = 0;
  bit           init_m   = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;

  // Monitor: model-based output checks and scoreboard pops on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      chk("rst_tready", {31'd0, s_if.tready}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      cnt_m      = 0;
      init_m     = 0;
      prev_stall = 0;
    end else begin
      chk("count", {29'd0, count}, cnt_m);
      chk("tready", {31'd0, s_if.tready}, {31'd0, (init_m && cnt_m < DEPTH)});
      chk("tvalid", {31'd0, m_if.tvalid}, {31'd0, (cnt_m != 0)});
      if (prev_stall) begin
        chk("stable_tdata", {24'd0, m_if.tdata}, {24'd0, prev_data});
      end
      if (m_if.tvalid && m_if.tready && !flush) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, m_if.tdata}, 32'hFFFF_FFFF);
        end else begin
          chk("tdata_order", {24'd0, m_if.tdata}, {24'd0, exp_q.pop_front()});
        end
      end
      if (flush) begin
        cnt_m = 0;
      end else begin
        cnt_m = cnt_m + int'(s_if.tvalid && s_if.tready) - int'(m_if.tvalid && m_if.tready);
      end
      init_m     = 1;
      prev_stall = m_if.tvalid && !m_if.tready && !flush;
      prev_data  = m_if.tdata;
    end
  end

  // One cycle of stimulus; records the beat the FIFO will accept at the next edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl,
                     output logic acc);
    s_if.tvalid = v;
    s_if.tdata  = d;
    m_if.tready = rdy;
    flush       = fl;
    acc         = v && s_if.tready;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  logic         a;
  logic         pend_v;
  logic [W-1:0] pend_d;
  int           sent;
  int           rx0;

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", {29'd0, count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("tready_before_edge", {31'd0, s_if.tready}, 32'd0);
    chk("tvalid_before_edge", {31'd0, m_if.tvalid}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, a);
    chk("tready_after_edge", {31'd0, s_if.tready}, 32'd1);

    // Fill to full with the consumer stalled, then hold off a fifth beat.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, a);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_tready", {31'd0, s_if.tready}, 32'd0);
    chk("full_tdata", {24'd0, m_if.tdata}, 32'h11);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h55, 1'b0, 1'b0, a);
      chk("held_off", {31'd0, a}, 32'd0);
    end
    cyc(1'b1, 8'h55, 1'b1, 1'b0, a);
    chk("full_pop_no_push", {31'd0, a}, 32'd0);
    chk("tready_reopens", {31'd0, s_if.tready}, 32'd1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, a);
    chk("fifth_accepted", {31'd0, a}, 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("drained", {29'd0, count}, 32'd0);

    // Streaming push and pop: occupancy stays at one across many wraps.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i), 1'b1, 1'b0, a);
      chk("stream_count", {29'd0, count}, 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("stream_empty", {29'd0, count}, 32'd0);

    // Flush coinciding with a push of 0xAA and a pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, a);
    chk("pre_flush_count", {29'd0, count}, 32'd3);
    cyc(1'b1, 8'hAA, 1'b1, 1'b1, a);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("flush_tready", {31'd0, s_if.tready}, 32'd1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, a);
    for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, a);

    // Random traffic at 50% on both sides; the producer holds a beat until accepted.
    rx0    = n_rx;
    sent   = 0;
    pend_v = 1'b0;
    pend_d = '0;
    for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() != 0); c++) begin
      if (!pend_v && sent < 1000 && $urandom_range(1, 0) == 1) begin
        pend_v = 1'b1;
        pend_d = 8'($urandom);
      end
      cyc(pend_v, pend_d, 1'($urandom_range(1, 0)), 1'b0, a);
      if (a) begin
        pend_v = 1'b0;
        sent++;
      end
    end
    chk("random_sent", sent, 32'd1000);
    chk("random_rx", n_rx - rx0, 32'd1000);

    // Asynchronous reset mid-stream with two beats stored.
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, a);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0, a);
    chk("pre_reset_count", {29'd0, count}, 32'd2);
    s_if.tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("async_tready", {31'd0, s_if.tready}, 32'd0);
    chk("async_count", {29'd0, count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, a);
    cyc(1'b1, 8'hD1, 1'b1, 1'b0, a);
    cyc(1'b1, 8'hD2, 1'b1, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("post_reset_empty", {29'd0, count}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
